// File: rtl/mem_hash_pipe_pkg.sv
// Shared types and helpers for the memory-hard hash pipeline.
package mem_hash_pkg;

    localparam int WORD_W      = 32;
    localparam int DEFAULT_MOD = 1193;

    // Control states of the hash core
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    // Rotate a 32-bit word left by n; n == 0 returns the word unchanged.
    function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] v,
                                                 input logic [4:0]        n);
        logic [2*WORD_W-1:0] dbl;
        dbl = {v, v} << n;
        return dbl[2*WORD_W-1:WORD_W];
    endfunction

endpackage

// File: rtl/mem_hash_mod.sv
// Registered exact x mod MOD for any 32-bit x.
// The quotient estimate floor(x * floor(2^32/MOD) / 2^32) is at most one
// below the true quotient, so a single conditional subtract finishes it.
module mem_hash_mod
    import mem_hash_pkg::*;
#(
    parameter int MOD = DEFAULT_MOD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] r
);

    localparam logic [63:0] MOD64 = 64'(MOD);
    localparam logic [63:0] RECIP = 64'h0000_0001_0000_0000 / MOD64;

    logic [WORD_W-1:0] quot_s;
    logic [63:0]       rem_s;
    logic [WORD_W-1:0] rem_fix_s;
    logic [WORD_W-1:0] r_r;

    // Reciprocal quotient estimate, partial remainder and final correction
    always_comb begin
        quot_s = 32'(({32'h0000_0000, x} * RECIP) >> 6'd32);
        rem_s  = {32'h0000_0000, x} - ({32'h0000_0000, quot_s} * MOD64);
        if (rem_s >= MOD64) begin
            rem_fix_s = 32'(rem_s - MOD64);
        end else begin
            rem_fix_s = 32'(rem_s);
        end
    end

    // Result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r <= 32'h0000_0000;
        end else begin
            r_r <= rem_fix_s;
        end
    end

    assign r = r_r;

endmodule

// File: rtl/mem_hash_pipe.sv
// Memory-hard hash core: loads a DEPTH x WORDS scratch memory, runs
// cfg_iters data-dependent mix iterations and presents the final state row
// on a valid/ready output. One iteration is in flight at a time; each takes
// clog2(WORDS)+5 cycles (rotate, adder tree, modulo, read, permute, update).
module mem_hash_pipe
    import mem_hash_pkg::*;
#(
    parameter int WORDS  = 32,
    parameter int DEPTH  = 32,
    parameter int MOD    = DEFAULT_MOD,
    parameter int ITER_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(DEPTH)-1:0] in_addr,
    input  logic [WORDS*WORD_W-1:0]  in_data,
    input  logic [ITER_W-1:0]        cfg_iters,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*WORD_W-1:0]  out_data,
    output logic                     busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int TL    = $clog2(WORDS);
    localparam int L     = TL + 5;
    localparam int VW    = L - 1;          // valid bits for every stage before the update
    localparam int ROW_W = WORDS * WORD_W;

    localparam logic [ITER_W-1:0] ITER_ZERO = {ITER_W{1'b0}};
    localparam logic [ITER_W-1:0] ITER_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]     LAST_ROW  = AW'(DEPTH - 1);

    // Control
    fsm_e              fsm_r;
    fsm_e              fsm_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              load_s;
    logic              start_s;
    logic              upd_s;
    logic              last_s;
    logic              launch_s;
    logic              hs_s;
    logic [ITER_W-1:0] iters_r;
    logic [ITER_W-1:0] iter_r;
    logic [VW-1:0]     vld_r;

    // State row and scratch memory
    logic [ROW_W-1:0]  state_r;
    logic [ROW_W-1:0]  state_upd_s;
    logic [ROW_W-1:0]  mem_r [DEPTH];
    logic              mem_we_s;
    logic [AW-1:0]     mem_wa_s;
    logic [ROW_W-1:0]  mem_wd_s;

    // Datapath
    logic [WORD_W-1:0] rot_s  [WORDS];
    logic [WORD_W-1:0] node_r [1:2*WORDS-1];  // heap-ordered adder tree, leaves at WORDS..
    logic [WORD_W-1:0] dir_s;
    logic [AW-1:0]     off_s;
    logic [WORD_W-1:0] sum_d1_r;
    logic [WORD_W-1:0] sum_d2_r;
    logic [4:0]        bits_r;
    logic [AW-1:0]     off_r;
    logic [AW-1:0]     off_d_r;
    logic [ROW_W-1:0]  tmp_r;
    logic [ROW_W-1:0]  tmp_d_r;
    logic [ROW_W-1:0]  perm_s;
    logic [ROW_W-1:0]  perm_r;

    // Handshake and sequencing qualifiers
    always_comb begin
        load_s   = (fsm_r == ST_IDLE) && in_valid;
        start_s  = load_s && (in_addr == LAST_ROW);
        upd_s    = (fsm_r == ST_RUN) && vld_r[VW-1];
        last_s   = (iter_r == (iters_r - ITER_ONE));
        launch_s = (fsm_r == ST_RUN) && (vld_r == {VW{1'b0}});
        hs_s     = (fsm_r == ST_DONE) && out_valid_r && out_ready;
    end

    // Next-state decode
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (cfg_iters == ITER_ZERO) begin
                        fsm_nxt_s = ST_DONE;
                    end else begin
                        fsm_nxt_s = ST_RUN;
                    end
                end else begin
                    fsm_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (upd_s && last_s) begin
                    fsm_nxt_s = ST_DONE;
                end else begin
                    fsm_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (hs_s) begin
                    fsm_nxt_s = ST_IDLE;
                end else begin
                    fsm_nxt_s = ST_DONE;
                end
            end
            default: begin
                fsm_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM register and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_nxt_s;
            in_ready_r  <= (fsm_nxt_s == ST_IDLE);
            out_valid_r <= (fsm_r == ST_DONE) && !hs_s;
            busy_r      <= (fsm_nxt_s == ST_RUN);
        end
    end

    // State row, iteration counters and stage valid shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= {ROW_W{1'b0}};
            iters_r <= ITER_ZERO;
            iter_r  <= ITER_ZERO;
            vld_r   <= {VW{1'b0}};
        end else begin
            if (start_s) begin
                state_r <= in_data;
                iters_r <= cfg_iters;
                iter_r  <= ITER_ZERO;
            end else if (upd_s) begin
                state_r <= state_upd_s;
                iter_r  <= iter_r + ITER_ONE;
            end
            vld_r <= {vld_r[VW-2:0], launch_s};
        end
    end

    // Per-word rotation of the state by (i+k) mod 32
    always_comb begin
        for (int k = 0; k < WORDS; k++) begin
            rot_s[k] = rotl32(state_r[k*WORD_W +: WORD_W], 5'(iter_r + ITER_W'(k)));
        end
    end

    // Rotate stage feeding a pipelined binary adder tree (one level per cycle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 1; n < 2 * WORDS; n++) begin
                node_r[n] <= 32'h0000_0000;
            end
        end else begin
            for (int k = 0; k < WORDS; k++) begin
                node_r[WORDS + k] <= rot_s[k];
            end
            for (int n = 1; n < WORDS; n++) begin
                node_r[n] <= node_r[2*n] + node_r[2*n + 1];
            end
        end
    end

    // Exact direction = sum mod MOD, one cycle after the tree root
    mem_hash_mod #(
        .MOD (MOD)
    ) u_mod (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (node_r[1]),
        .r     (dir_s)
    );

    assign off_s = AW'(dir_s >> 5'd5);

    // Word permutation by (i+k) mod WORDS, rotate by dir[4:0], mix in the sum
    always_comb begin
        for (int k = 0; k < WORDS; k++) begin
            perm_s[k*WORD_W +: WORD_W] =
                rotl32(tmp_r[TL'(iter_r + ITER_W'(k))*WORD_W +: WORD_W], bits_r) ^ sum_d2_r;
        end
    end

    // Sum alignment, memory read, and permute stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_d1_r <= 32'h0000_0000;
            sum_d2_r <= 32'h0000_0000;
            bits_r   <= 5'd0;
            off_r    <= {AW{1'b0}};
            off_d_r  <= {AW{1'b0}};
            tmp_r    <= {ROW_W{1'b0}};
            tmp_d_r  <= {ROW_W{1'b0}};
            perm_r   <= {ROW_W{1'b0}};
        end else begin
            sum_d1_r <= node_r[1];
            sum_d2_r <= sum_d1_r;
            bits_r   <= dir_s[4:0];
            off_r    <= off_s;
            tmp_r    <= mem_r[off_s];
            off_d_r  <= off_r;
            tmp_d_r  <= tmp_r;
            perm_r   <= perm_s;
        end
    end

    // Updated state words (mod 2^32 per word)
    always_comb begin
        for (int k = 0; k < WORDS; k++) begin
            state_upd_s[k*WORD_W +: WORD_W] = state_r[k*WORD_W +: WORD_W]
                                            + perm_r[k*WORD_W +: WORD_W];
        end
    end

    // Single write port: load beats while idle, write-back on iteration update
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = {AW{1'b0}};
        mem_wd_s = {ROW_W{1'b0}};
        if (load_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = in_addr;
            mem_wd_s = in_data;
        end else if (upd_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = off_d_r;
            mem_wd_s = tmp_d_r ^ state_upd_s;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Scratch memory array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = state_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_hash_pipe.sv
// Randomized self-checking bench for mem_hash_pipe against a word-level
// reference model of the hash iteration rules.
module tb_mem_hash_pipe;

    localparam int WORDS  = 32;
    localparam int DEPTH  = 32;
    localparam int MOD    = 1193;
    localparam int ITER_W = 12;
    localparam int L      = $clog2(WORDS) + 5;
    localparam int AW     = $clog2(DEPTH);
    localparam int ROW_W  = WORDS * 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_addr;
    logic [ROW_W-1:0]  in_data;
    logic [ITER_W-1:0] cfg_iters;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_data;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rows   [DEPTH][WORDS];
    logic [31:0] exp_st [WORDS];

    mem_hash_pipe #(
        .WORDS  (WORDS),
        .DEPTH  (DEPTH),
        .MOD    (MOD),
        .ITER_W (ITER_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .cfg_iters (cfg_iters),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare, count, report a mismatch
    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference: plain sequential application of the iteration rules
    task automatic model(input int iters);
        logic [31:0] mm  [DEPTH][WORDS];
        logic [31:0] st  [WORDS];
        logic [31:0] tmp [WORDS];
        logic [31:0] sum;
        logic [31:0] dir;
        int bits;
        int off;
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < WORDS; k++) mm[a][k] = rows[a][k];
        for (int k = 0; k < WORDS; k++) st[k] = rows[DEPTH-1][k];
        for (int i = 0; i < iters; i++) begin
            sum = 32'd0;
            for (int k = 0; k < WORDS; k++) sum = sum + rl(st[k], (i + k) % 32);
            dir  = sum % 32'(MOD);
            bits = int'(dir % 32'd32);
            off  = int'((dir / 32'd32) % 32'(DEPTH));
            for (int k = 0; k < WORDS; k++) tmp[k] = mm[off][k];
            for (int k = 0; k < WORDS; k++) st[k] = st[k] + (rl(tmp[(i + k) % WORDS], bits) ^ sum);
            for (int k = 0; k < WORDS; k++) mm[off][k] = tmp[k] ^ st[k];
        end
        for (int k = 0; k < WORDS; k++) exp_st[k] = st[k];
    endtask

    function automatic logic [ROW_W-1:0] pack_row(input int a);
        logic [ROW_W-1:0] v;
        for (int k = 0; k < WORDS; k++) v[k*32 +: 32] = rows[a][k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rows();
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < WORDS; k++) rows[a][k] = 32'd0;
    endtask

    task automatic random_rows();
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < WORDS; k++) rows[a][k] = $urandom();
    endtask

    task automatic drive_noise();
        in_valid  = 1'($urandom_range(0, 1));
        in_addr   = AW'($urandom_range(0, DEPTH - 1));
        for (int k = 0; k < WORDS; k++) in_data[k*32 +: 32] = $urandom();
        cfg_iters = ITER_W'($urandom_range(0, 7));
    endtask

    // Load all rows; the final beat (last row) is the start beat
    task automatic load_all(input int iters);
        for (int a = 0; a < DEPTH; a++) begin
            in_valid  = 1'b1;
            in_addr   = AW'(a);
            in_data   = pack_row(a);
            cfg_iters = ITER_W'(iters);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_hash(input string nm, input int iters, input int hold, input bit noise);
        int lat;
        int budget;
        model(iters);
        chk_eq({nm, "_rdy_pre"}, 64'(in_ready), 64'd1);
        load_all(iters);
        chk_eq({nm, "_busy"}, 64'(busy), (iters > 0) ? 64'd1 : 64'd0);
        chk_eq({nm, "_rdy_run"}, 64'(in_ready), 64'd0);
        lat    = 0;
        budget = iters * L + 20;
        while (out_valid !== 1'b1 && lat < budget) begin
            if (noise) drive_noise();
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk_eq({nm, "_latency"}, 64'(lat), 64'(iters * L + 1));
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                drive_noise();
                in_addr = AW'(DEPTH - 1);
            end
            tick();
            chk_eq($sformatf("%s_hold_vld%0d", nm, h), 64'(out_valid), 64'd1);
            chk_eq($sformatf("%s_hold_rdy%0d", nm, h), 64'(in_ready), 64'd0);
            chk_eq($sformatf("%s_hold_w%0d", nm, h % WORDS),
                   64'(out_data[(h % WORDS)*32 +: 32]), 64'(exp_st[h % WORDS]));
        end
        in_valid = 1'b0;
        for (int k = 0; k < WORDS; k++)
            chk_eq($sformatf("%s_w%0d", nm, k), 64'(out_data[k*32 +: 32]), 64'(exp_st[k]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_eq({nm, "_vld_post"}, 64'(out_valid), 64'd0);
        chk_eq({nm, "_rdy_post"}, 64'(in_ready), 64'd1);
        chk_eq({nm, "_busy_post"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        cfg_iters = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
        chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_data_lo", 64'(out_data[63:0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // All rows zero, one iteration
        clear_rows();
        run_hash("zero", 1, 0, 1'b0);

        // Zero iterations returns the start row
        clear_rows();
        for (int k = 0; k < WORDS; k++) rows[DEPTH-1][k] = 32'(k + 1);
        run_hash("iter0", 0, 2, 1'b0);

        // Single set bit: sum=1, dir=1, off=0
        clear_rows();
        rows[DEPTH-1][0] = 32'd1;
        run_hash("one", 1, 0, 1'b0);
        chk_eq("one_w0_const", 64'(out_data[31:0]), 64'd2);
        chk_eq("one_w1_const", 64'(out_data[63:32]), 64'd1);

        // Largest 32-bit sum and a sum equal to the modulus
        clear_rows();
        rows[DEPTH-1][0] = 32'hFFFF_FFFF;
        run_hash("allones", 1, 0, 1'b0);
        clear_rows();
        rows[DEPTH-1][0] = 32'(MOD);
        run_hash("summod", 1, 0, 1'b0);

        // Long run with output back-pressure and ignored beats
        random_rows();
        run_hash("long", 256, 40, 1'b1);

        // Reset in the middle of iteration 100
        random_rows();
        load_all(200);
        repeat (100 * L + 3) tick();
        chk_eq("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("mid_rst_busy", 64'(busy), 64'd0);
        chk_eq("mid_rst_data_lo", 64'(out_data[63:0]), 64'd0);
        chk_eq("mid_rst_data_hi", 64'(out_data[ROW_W-1 -: 64]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        random_rows();
        run_hash("reload", 3, 1, 1'b0);

        // A few short random hashes
        for (int r = 0; r < 3; r++) begin
            random_rows();
            run_hash($sformatf("rnd%0d", r), $urandom_range(1, 20), $urandom_range(0, 5), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_hash_pipe.md
# mem_hash_pipe

Parametrised memory-hard hash core for the proof pipeline. It accepts a DEPTH-row scratch memory of WORDS×32-bit rows and runs a runtime-configurable number of data-dependent mix iterations over it. It returns the final state row through a valid/ready output handshake. It is the next generation of the fixed 32×32 hash core and adds:
- generic width and depth;
- an exact modulo;
- a runtime iteration count;
- output back-pressure.

## Interface
- WORDS, 32: 32-bit words per row; power of two, 4..32
- DEPTH, 32: rows of scratch memory; power of two, 4..64
- MOD, 1193: modulus for direction; 2..2^20
- ITER_W, 12: width of cfg_iters
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  load beat valid
- in_ready  out  1  core accepts load beats (idle)
- in_addr  in  clog2(DEPTH)  row address of load beat
- in_data  in  WORDS*32  row data, word k at [k*32+:32]
- cfg_iters  in  ITER_W  iteration count, sampled on start beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WORDS*32  final state row
- busy  out  1  iterations in progress

## Operation
- States: IDLE, RUN, DONE.
- IDLE, in_valid && in_ready: mem[in_addr] <= in_data.
- Beat with in_addr == DEPTH-1 is the start beat. It writes the row, sets state <= in_data and latches cfg_iters. It clears i and moves to RUN. If cfg_iters == 0, it goes directly to DONE instead.
- Rows not written since reset hold undefined contents. The bench always loads all DEPTH rows.
- Iteration i (0-based), all arithmetic mod 2^32, rotl by 0 = identity:
  - sum = Σk rotl(state[k], (i+k) mod 32)
  - dir = sum mod MOD (exact for all 32-bit sum)
  - bits = dir[4:0]
  - off = (dir>>5) mod DEPTH
  - tmp = mem[off]
  - state'[k] = state[k] + (rotl(tmp[(i+k) mod WORDS], bits) ^ sum)
  - mem[off] <= tmp ^ state'
- After iteration cfg_iters-1 the FSM moves to DONE.
- DONE: out_valid=1, out_data=state, stable until out_valid && out_ready. Handshake returns the FSM to IDLE.
- in_ready = (FSM == IDLE). Beats while not idle are ignored. busy = (FSM == RUN).
- out_ready is ignored outside DONE.
- rst_n low, any state: FSM->IDLE, in_ready=1, out_valid=0, busy=0, state=0 (out_data=0), pipeline valids cleared. Memory is not cleared.
- A reset mid-RUN discards the iteration. Loading after reset works normally.

## Timing
- L = clog2(WORDS) + 5 cycles per iteration. Pipeline stages:
  1. rotate
  2. L-5 adder-tree levels
  3. modulo
  4. memory read
  5. permute+rotate
  6. state update and memory write-back
- One iteration in flight; iteration i+1 stage 1 uses state' from iteration i's update cycle.
- Start beat at edge T: out_valid rises at edge T + cfg_iters·L + 1. For cfg_iters==0: T+1.
- Write-back and next read never alias in the same cycle; the write completes before the following iteration's read stage.
- in_ready returns the cycle after the output handshake.
- Throughput: one hash per (DEPTH + cfg_iters·L + 2) cycles minimum.

## Structure
- Package mem_hash_pkg:
  - WORD_W = 32
  - DEFAULT_MOD = 1193
  - function rotl32(v, n)
  - FSM state typedef
- Sub-module mem_hash_mod: registered exact x mod MOD for 32-bit x.
  - Reciprocal multiply-shift plus one conditional subtract.
  - Latency 1.
- Scratch memory: distributed RAM, one write port, one read port.

## Test plan
- All rows zero, cfg_iters=1 -> out_valid at T+11 (WORDS=32), out_data all zero.
- cfg_iters=0, row 31 = 0x0000_0001..0x0000_0020 -> out_valid at T+1, out_data equals row 31.
- Rows zero except row31 word0=1, cfg_iters=1 -> sum=1, dir=1, off=0. out_data word0=2, others 1; mem[0] = that row.
- Row31 word0=0xFFFF_FFFF, rest zero, cfg_iters=1 -> sum=0xFFFF_FFFF, dir=275 (bits=19, off=8). Row31 word0=1193 -> dir=0. Both results match the reference model.
- Random rows, cfg_iters=256, out_ready low 40 cycles:
  - out_data stable, in_ready=0, in_valid beats ignored;
  - after handshake, in_ready=1 next cycle;
  - result matches the reference model.
- rst_n pulsed low mid-RUN at iteration 100 -> outputs reset immediately. A reload with cfg_iters=3 produces the correct model result.
